// File: rtl/router_pkg.sv
// Shared router definitions: controller state encoding, port addresses and a
// helper that picks the per-port flag addressed by a 2-bit port number.
package router_pkg;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_e;

  localparam logic [1:0] PORT0        = 2'd0;
  localparam logic [1:0] PORT1        = 2'd1;
  localparam logic [1:0] PORT2        = 2'd2;
  localparam logic [1:0] ADDR_INVALID = 2'd3;

  // The invalid address has no FIFO behind it, so its flag always reads low.
  function automatic logic port_flag(input logic [2:0] flags, input logic [1:0] port);
    logic sel;
    case (port)
      PORT0:   sel = flags[0];
      PORT1:   sel = flags[1];
      PORT2:   sel = flags[2];
      default: sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/router_fsm_if.sv
// Handshake bundle between the router controller and its neighbours
// (packet source, synchronizer, register block and output FIFOs).
interface router_fsm_if;

  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;

  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       write_enb_reg;
  logic       rst_int_reg;
  logic       busy;

  modport master (
    output pkt_valid, data_in, fifo_full,
    output fifo_empty_0, fifo_empty_1, fifo_empty_2,
    output soft_reset_0, soft_reset_1, soft_reset_2,
    output parity_done, low_pkt_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
    input  write_enb_reg, rst_int_reg, busy
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
    input  soft_reset_0, soft_reset_1, soft_reset_2,
    input  parity_done, low_pkt_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
    output write_enb_reg, rst_int_reg, busy
  );

endinterface

// File: rtl/router_fsm.sv
// Router packet controller: a Moore FSM that walks each packet from header
// decode through payload, FIFO-full stalls and parity, plus the latched port address.
module router_fsm
  import router_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  router_fsm_if.slave  bus
);

  router_state_e state_q, state_d;
  logic [1:0]    addr_q, addr_d;
  logic [2:0]    empty_vec;
  logic [2:0]    soft_vec;

  assign empty_vec = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
  assign soft_vec  = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= PORT0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    state_d = state_q;

    // The header address is captured even when invalid; only a valid one starts a packet.
    if (state_q == DECODE_ADDRESS && bus.pkt_valid) begin
      addr_d = bus.data_in;
    end

    case (state_q)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid && bus.data_in != ADDR_INVALID) begin
          state_d = port_flag(empty_vec, bus.data_in) ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (port_flag(empty_vec, addr_q)) begin
          state_d = LOAD_FIRST_DATA;
        end
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full) begin
          state_d = FIFO_FULL_STATE;
        end else if (!bus.pkt_valid) begin
          state_d = LOAD_PARITY;
        end
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) begin
          state_d = LOAD_AFTER_FULL;
        end
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done) begin
          state_d = DECODE_ADDRESS;
        end else if (bus.low_pkt_valid) begin
          state_d = LOAD_PARITY;
        end else begin
          state_d = LOAD_DATA;
        end
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase

    // A read timeout on the port being written abandons the packet outright.
    if (port_flag(soft_vec, addr_q)) begin
      state_d = DECODE_ADDRESS;
    end
  end

  always_comb begin
    bus.detect_add    = (state_q == DECODE_ADDRESS);
    bus.lfd_state     = (state_q == LOAD_FIRST_DATA);
    bus.ld_state      = (state_q == LOAD_DATA);
    bus.laf_state     = (state_q == LOAD_AFTER_FULL);
    bus.full_state    = (state_q == FIFO_FULL_STATE);
    bus.rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    bus.write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                        (state_q == LOAD_AFTER_FULL);
    bus.busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios followed by randomized traffic,
// all checked against a table-driven behavioural model of the controller.
module tb_router_fsm;

  logic clock;
  logic reset;

  router_fsm_if bus ();

  router_fsm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int {M_DA, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE, M_WTE} model_state_t;

  // Bit order: detect_add lfd ld laf full write_enb rst_int busy
  localparam logic [7:0] EXP_OUT [8] = '{
    8'b1000_0000,   // M_DA
    8'b0100_0001,   // M_LFD
    8'b0010_0100,   // M_LD
    8'b0000_1001,   // M_FFS
    8'b0001_0101,   // M_LAF
    8'b0000_0101,   // M_LP
    8'b0000_0011,   // M_CPE
    8'b0000_0001    // M_WTE
  };

  model_state_t m_state;
  int           m_addr;
  int           checks;
  int           errors;
  int           wenb_count;
  int           busy_count;

  function automatic logic [7:0] observed();
    return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
            bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
  endfunction

  function automatic bit flag_of(input logic [2:0] flags, input int port);
    return (port >= 0 && port < 3) ? bit'(flags[port]) : 1'b0;
  endfunction

  task automatic model_reset();
    m_state = M_DA;
    m_addr  = 0;
  endtask

  task automatic model_step();
    model_state_t nxt;
    int           a_old;
    logic [2:0]   empties;
    logic [2:0]   softs;
    if (reset) begin
      model_reset();
      return;
    end
    nxt     = m_state;
    a_old   = m_addr;
    empties = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
    softs   = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
    case (m_state)
      M_DA:  if (bus.pkt_valid && int'(bus.data_in) != 3)
               nxt = flag_of(empties, int'(bus.data_in)) ? M_LFD : M_WTE;
      M_WTE: if (flag_of(empties, a_old)) nxt = M_LFD;
      M_LFD: nxt = M_LD;
      M_LD:  if (bus.fifo_full) nxt = M_FFS; else if (!bus.pkt_valid) nxt = M_LP;
      M_FFS: if (!bus.fifo_full) nxt = M_LAF;
      M_LAF: nxt = bus.parity_done ? M_DA : (bus.low_pkt_valid ? M_LP : M_LD);
      M_LP:  nxt = M_CPE;
      M_CPE: nxt = bus.fifo_full ? M_FFS : M_DA;
      default: nxt = M_DA;
    endcase
    if (m_state == M_DA && bus.pkt_valid) m_addr = int'(bus.data_in);
    if (flag_of(softs, a_old)) nxt = M_DA;
    m_state = nxt;
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (observed() === EXP_OUT[int'(m_state)])
    else begin
      errors++;
      $error("[TB] FAIL %s: outputs observed=%b expected=%b", tag, observed(), EXP_OUT[int'(m_state)]);
    end
  endtask

  task automatic checkValue(input string tag, input int got, input int want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [1:0] din, input logic ff,
                               input logic [2:0] fe, input logic [2:0] sr,
                               input logic pd, input logic lpv);
    bus.pkt_valid     = pv;
    bus.data_in       = din;
    bus.fifo_full     = ff;
    bus.fifo_empty_0  = fe[0];
    bus.fifo_empty_1  = fe[1];
    bus.fifo_empty_2  = fe[2];
    bus.soft_reset_0  = sr[0];
    bus.soft_reset_1  = sr[1];
    bus.soft_reset_2  = sr[2];
    bus.parity_done   = pd;
    bus.low_pkt_valid = lpv;
  endtask

  // One clock: advance the model on the edge, compare just after it.
  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    checkOutput(tag);
    if (bus.write_enb_reg === 1'b1) wenb_count++;
    if (bus.busy === 1'b1) busy_count++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    model_reset();
    #1;
    checkOutput("reset_state");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Normal packet to port 1
    applyStimulus(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    wenb_count = 0;
    busy_count = 0;
    tick("pkt1_lfd");
    tick("pkt1_ld0");
    tick("pkt1_ld1");
    tick("pkt1_ld2");
    bus.pkt_valid = 1'b0;
    tick("pkt1_lp");
    tick("pkt1_cpe");
    tick("pkt1_da");
    checkValue("pkt1_wenb_cycles", wenb_count, 4);
    checkValue("pkt1_busy_cycles", busy_count, 3);

    // Invalid address never starts a packet
    applyStimulus(1'b1, 2'd3, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    wenb_count = 0;
    for (int i = 0; i < 5; i++) tick("invalid_addr");
    checkValue("invalid_wenb_cycles", wenb_count, 0);
    checkValue("invalid_detect_add", int'(bus.detect_add), 1);

    // Destination FIFO not empty: wait, then load
    applyStimulus(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    busy_count = 0;
    for (int i = 0; i < 4; i++) tick("wait_empty");
    checkValue("wait_busy_cycles", busy_count, 4);
    bus.fifo_empty_2 = 1'b1;
    tick("wait_to_lfd");
    checkValue("wait_lfd_busy", int'(bus.busy), 1);

    // FIFO full stall, recovery, then low_pkt_valid path to parity
    tick("full_ld");
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) tick("full_hold");
    checkValue("full_state_flag", int'(bus.full_state), 1);
    bus.fifo_full = 1'b0;
    tick("full_to_laf");
    bus.low_pkt_valid = 1'b1;
    tick("laf_to_lp");
    bus.low_pkt_valid = 1'b0;
    bus.pkt_valid     = 1'b0;
    tick("full_cpe");
    tick("full_da");

    // Soft reset of another port is ignored; soft reset of addr aborts
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    tick("soft_lfd");
    tick("soft_ld");
    bus.soft_reset_1 = 1'b1;
    tick("soft_other_port");
    bus.soft_reset_1 = 1'b0;
    bus.soft_reset_0 = 1'b1;
    tick("soft_own_port");
    bus.soft_reset_0 = 1'b0;
    bus.pkt_valid    = 1'b0;
    tick("soft_idle");

    // Asynchronous reset while in FIFO_FULL_STATE
    applyStimulus(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    tick("areset_lfd");
    tick("areset_ld");
    bus.fifo_full = 1'b1;
    tick("areset_ffs");
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    checkOutput("areset_immediate");
    checkValue("areset_full_state", int'(bus.full_state), 0);
    tick("areset_held");
    #3;
    reset = 1'b0;
    bus.fifo_full = 1'b0;
    tick("areset_first_edge");

    // Randomized traffic with occasional soft resets and async resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(3) != 0), 2'($urandom_range(3)),
                    1'($urandom_range(3) == 0), 3'($urandom_range(7)),
                    {1'($urandom_range(15) == 0), 1'($urandom_range(15) == 0),
                     1'($urandom_range(15) == 0)},
                    1'($urandom_range(3) == 0), 1'($urandom_range(1)));
      if ($urandom_range(49) == 0) begin
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checkOutput("rand_async_reset");
        #1;
        reset = 1'b0;
      end
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
